// File: rtl/rambist_if.sv
// Memory-side bus between the BIST engine and the single-port RAM: ce/we/addr/din out, registered dout back.
// The BIST drives every request field; dout is valid the cycle after a read was issued.
interface rambist_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          ce;
  logic [DW-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output ce, output we, output addr, output din, input dout);
  modport slave  (input ce, input we, input addr, input din, output dout);
endinterface

// File: rtl/rambist.sv
// March C- BIST for a 1-cycle-read single-port RAM; RAMBIST_STOP_ON_FAIL_EN ends the test at the first mismatch.
// Latency: done rises 10N+2 edges after the start edge; no backpressure, start is ignored while busy.
module rambist #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [7:0]    err_count,
  rambist_if.master     mem
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam logic [AW-1:0] ALAST = '1;

  state_t        state;
  logic [2:0]    elem;
  logic [AW-1:0] addr;
  logic          ph;
  logic          fin;
  logic [2:0]    op_elem;
  logic [DW-1:0] op_exp;
  logic          chk_vld;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] chk_exp;
  logic [2:0]    chk_elem;

  logic          is_rd;
  logic          at_end;
  logic          mism;
  logic          first;
  logic          stop_hit;
  logic [7:0]    err_nxt;

  // Element table: E0 w0, E1 r0w1, E2 r1w0 (up); E3 r0w1, E4 r1w0, E5 r0 (down).
  function automatic logic el_rd(input logic [2:0] e);
    return e != 3'd0;
  endfunction

  function automatic logic el_wr(input logic [2:0] e);
    return e != 3'd5;
  endfunction

  function automatic logic el_dn(input logic [2:0] e);
    return e >= 3'd3;
  endfunction

  function automatic logic [DW-1:0] el_rpat(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  function automatic logic [DW-1:0] el_wpat(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  always_comb begin
    is_rd   = !ph && el_rd(elem);
    at_end  = el_dn(elem) ? (addr == '0) : (addr == ALAST);
    mism    = (state == RUN || state == CHECK) && chk_vld && (mem.dout != chk_exp);
    first   = mism && (err_count == 8'd0);
    err_nxt = (mism && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

`ifdef RAMBIST_STOP_ON_FAIL_EN
  assign stop_hit = mism;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_count <= '0;
      elem      <= '0;
      addr      <= '0;
      ph        <= 1'b0;
      fin       <= 1'b0;
      op_elem   <= '0;
      op_exp    <= '0;
      chk_vld   <= 1'b0;
      chk_addr  <= '0;
      chk_exp   <= '0;
      chk_elem  <= '0;
      mem.ce    <= 1'b0;
      mem.we    <= '0;
      mem.addr  <= '0;
      mem.din   <= '0;
    end else begin
      // Read issued this cycle is checked next cycle, when the RAM's registered dout is valid.
      chk_vld  <= mem.ce && (mem.we == '0);
      chk_addr <= mem.addr;
      chk_exp  <= op_exp;
      chk_elem <= op_elem;

      if (mism) err_count <= err_nxt;
      if (first) begin
        fail_addr <= chk_addr;
        fail_elem <= chk_elem;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            err_count <= '0;
            elem      <= '0;
            addr      <= '0;
            ph        <= 1'b0;
            fin       <= 1'b0;
          end
        end

        RUN: begin
          if (stop_hit) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= 1'b0;
            mem.ce <= 1'b0;
            mem.we <= '0;
          end else if (fin) begin
            state  <= CHECK;
            mem.ce <= 1'b0;
            mem.we <= '0;
          end else begin
            mem.ce   <= 1'b1;
            mem.addr <= addr;
            op_elem  <= elem;
            if (is_rd) begin
              mem.we <= '0;
              op_exp <= el_rpat(elem);
            end else begin
              mem.we  <= '1;
              mem.din <= el_wpat(elem);
            end

            if (is_rd && el_wr(elem)) begin
              ph <= 1'b1;
            end else begin
              ph <= 1'b0;
              if (at_end) begin
                if (elem == 3'd5) begin
                  fin <= 1'b1;
                end else begin
                  elem <= elem + 3'd1;
                  addr <= el_dn(elem + 3'd1) ? ALAST : '0;
                end
              end else begin
                addr <= el_dn(elem) ? addr - 1'b1 : addr + 1'b1;
              end
            end
          end
        end

        CHECK: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_nxt == 8'd0);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rambist.sv
// Directed bench for rambist (DW=8, AW=3) against a bit-masked RAM model with injectable stuck-at faults.
module tb_rambist;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 8;

`ifdef RAMBIST_STOP_ON_FAIL_EN
  localparam int SA1_DONE = 21;
  localparam int SA1_ERR  = 1;
  localparam int SA0_DONE = 27;
  localparam int SA0_ERR  = 1;
`else
  localparam int SA1_DONE = 82;
  localparam int SA1_ERR  = 3;
  localparam int SA0_DONE = 82;
  localparam int SA0_ERR  = 2;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [7:0]    err_count;

  logic [DW-1:0] ram [0:N-1];
  logic [DW-1:0] sa1;
  logic [DW-1:0] sa0;
  logic [AW-1:0] faddr;

  int tests = 0;
  int fails = 0;
  int n;

  rambist_if #(.DW(DW), .AW(AW)) mif ();

  rambist #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .err_count (err_count),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.ce) begin
      for (int i = 0; i < DW; i++)
        if (mif.we[i]) ram[mif.addr][i] <= mif.din[i];
      if (mif.we == '0)
        mif.dout <= (mif.addr == faddr) ? ((ram[mif.addr] | sa1) & ~sa0) : ram[mif.addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected k-th issued operation (k = 1..10N) of a March C- run.
  function automatic void exp_op(input int k, output logic [AW-1:0] a, output logic w,
                                 output logic [DW-1:0] d);
    int j;
    int idx;
    j = k - 1;
    w = 1'b0;
    d = '0;
    if (j < N) begin
      a = AW'(j);
      w = 1'b1;
      return;
    end
    j -= N;
    for (int e = 1; e <= 4; e++) begin
      if (j < 2 * N) begin
        idx = j / 2;
        a   = (e >= 3) ? AW'(N - 1 - idx) : AW'(idx);
        w   = (j % 2) == 1;
        d   = (e == 1 || e == 3) ? 8'hFF : 8'h00;
        return;
      end
      j -= 2 * N;
    end
    a = AW'(N - 1 - j);
  endfunction

  task automatic run(input bit seq, input int restart_at, output int cnt);
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_rise", busy, 1);
    check("done_clear", done, 0);
    cnt = 0;
    while (!done && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == restart_at - 1) start = 1'b1;
      if (cnt == restart_at) start = 1'b0;
      if (seq && cnt <= 10 * N) begin
        exp_op(cnt, ea, ew, ed);
        check($sformatf("op%0d", cnt),
              {mif.ce, mif.we, mif.addr, ew ? mif.din : 8'h00},
              {1'b1, ew ? 8'hFF : 8'h00, ea, ew ? ed : 8'h00});
      end
      if (seq && cnt == 10 * N + 1) check("ce_in_check", mif.ce, 0);
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    nreset = 1'b1;
    start  = 1'b0;
    sa1    = '0;
    sa0    = '0;
    faddr  = '0;
    #3 nreset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ce", mif.ce, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    repeat (2) @(posedge clk);

    // Fault-free run with full issue-sequence check.
    run(1'b1, 0, n);
    check("clean_latency", n, 82);
    check("clean_busy", busy, 0);
    check("clean_pass", pass, 1);
    check("clean_err", err_count, 0);
    check("clean_faddr", fail_addr, 0);
    check("clean_felem", fail_elem, 0);
    check("clean_ce", mif.ce, 0);

    // Bit 3 stuck-at-1 at address 5.
    sa1 = 8'h08; faddr = 3'd5;
    run(1'b0, 0, n);
    check("sa1_latency", n, SA1_DONE);
    check("sa1_pass", pass, 0);
    check("sa1_felem", fail_elem, 1);
    check("sa1_faddr", fail_addr, 5);
    check("sa1_err", err_count, SA1_ERR);
    repeat (3) @(posedge clk);
    #1 check("sa1_ce_after", mif.ce, 0);
    check("sa1_err_hold", err_count, SA1_ERR);

    // Bit 0 stuck-at-0 at address 0.
    sa1 = '0; sa0 = 8'h01; faddr = 3'd0;
    run(1'b0, 0, n);
    check("sa0_latency", n, SA0_DONE);
    check("sa0_pass", pass, 0);
    check("sa0_felem", fail_elem, 2);
    check("sa0_faddr", fail_addr, 0);
    check("sa0_err", err_count, SA0_ERR);
    sa0 = '0;

    // Asynchronous reset in the middle of a run.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err_count, 0);
    check("arst_bus", {mif.ce, mif.we, mif.addr, mif.din}, 0);
    @(negedge clk) nreset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("arst_no_restart", busy, 0);
    run(1'b0, 0, n);
    check("arst_rerun_latency", n, 82);
    check("arst_rerun_pass", pass, 1);

    // Start while busy is ignored; start while done reruns.
    run(1'b0, 10, n);
    check("rebusy_latency", n, 82);
    check("rebusy_pass", pass, 1);
    run(1'b1, 0, n);
    check("redone_latency", n, 82);
    check("redone_pass", pass, 1);
    check("redone_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rambist.md
Name: rambist

Overview:
- March C- built-in self-test engine that sits directly upstream of the bit-masked single-port RAM (rambit).
- Drives the RAM's ce/we/addr/din and consumes its registered dout, which has 1-cycle read latency.
- Reports pass/fail, the first failing address and March element, and an error count.
- Used for production test and for benchmarking the memory plus its test wrapper.

Parameters:
- DW, 32, RAM data width; must match the attached RAM.
- AW, 10, RAM address width; N = 2**AW words.

Ports:
- clk  input  1  clock; also clocks the RAM.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a test.
- busy  output  1  high while the test runs.
- done  output  1  high from test end until the next accepted start.
- pass  output  1  valid while done; 1 = no mismatch.
- fail_addr  output  AW  address of the first mismatch.
- fail_elem  output  3  March element (0-5) of the first mismatch.
- err_count  output  8  saturating mismatch count.
- mem_ce  output  1  to RAM ce.
- mem_we  output  DW  to RAM we; all ones = write, all zeros = read.
- mem_addr  output  AW  to RAM addr.
- mem_din  output  DW  to RAM din.
- mem_dout  input  DW  from RAM dout.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low on nreset.
- Reset values: all outputs 0, mem_ce=0, state IDLE.
- Reset mid-test aborts immediately with no pending write completion; the next test needs a new start.
- States: IDLE, RUN, CHECK, DONE.
- IDLE or DONE + start: clear done, pass, fail_addr, fail_elem, err_count; go to RUN; busy=1 next cycle.
- Start while busy is ignored.
- Elements, with pattern 0 = all zeros and 1 = all ones:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 down(r0)
- Up = address 0 to N-1; down = N-1 to 0. The address counter wraps per element, with no skipped or repeated address.
- Per address:
  - w-only: 1 cycle.
  - r,w: read cycle (mem_ce=1, mem_we=0), then write cycle (mem_ce=1, mem_we all ones, mem_din = new pattern).
  - r-only: 1 cycle.
- Elements run back-to-back with no idle cycles. Total RUN issue cycles = 10N.
- mem_ce=0 in IDLE, CHECK and DONE.
- Compare pipeline:
  - Every read cycle sets chk_vld, chk_addr and chk_exp for the following cycle.
  - In that cycle, mem_dout is compared with chk_exp over all DW bits.
- Mismatch:
  - err_count increments, saturating at 255.
  - On the first mismatch only: capture fail_addr=chk_addr, fail_elem=chk_elem.
- After the last E5 read, enter CHECK for one cycle to compare the final read, then DONE.
  - busy=0 and done=1 from the edge after CHECK.
  - pass = (err_count==0).
- Latency: done rises 10N+2 clock edges after the edge that sampled start.
- Outputs are registered. fail_addr/fail_elem hold 0 when pass=1.

Optional Feature:
- Macro RAMBIST_STOP_ON_FAIL_EN.
- Defined: on the first mismatch, go to DONE at the next edge.
  - A write pending at the same cycle is still issued; no further operations follow.
  - pass=0, err_count=1.
- Undefined: the test always runs to completion and records the first failure plus the saturating count.

Test Plan:
- DW=8, AW=3, fault-free RAM model; start pulse -> busy 1 cycle later, done at edge 82, pass=1, err_count=0; mem_addr sequence checked per element.
- Bit 3 stuck-at-1 at addr 5 -> fail_elem=1, fail_addr=5, pass=0; err_count=3 (fails in E1, E3, E5).
- Bit 0 stuck-at-0 at addr 0 -> first failure fail_elem=2, fail_addr=0; err_count=2 (E2, E4).
- nreset asserted at cycle 20 of a run -> all outputs 0 asynchronously; a new start gives a clean pass at +82.
- start pulsed again at cycle 10 while busy -> ignored; done still at edge 82; start while done -> done clears, test reruns.
- With RAMBIST_STOP_ON_FAIL_EN and the stuck-at-1 case -> done 1 edge after the E1 addr-5 compare, err_count=1, mem_ce=0 afterwards.
